// File: rtl/ssm2603_adc_receiver.sv
//------------------------------------------------------------------------------
// Module   : ssm2603_adc_receiver
// Brief    : SSM2603 ADC-side I2S receiver; oversampled deserializer with a
//            valid/ready pair output and sticky overrun flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ssm2603_adc_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             bclk_in,
    input  logic             lrclk_in,
    input  logic             adcdat_in,
    output logic [WIDTH-1:0] sample_l,
    output logic [WIDTH-1:0] sample_r,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             overrun_clear,
    output logic             locked
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(WIDTH);
    localparam logic [WIDTH-1:0]   c_msb   = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_left = 2'd1;
    localparam logic [1:0] c_st_left      = 2'd2;
    localparam logic [1:0] c_st_right     = 2'd3;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrclk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_bclk_prev;
    logic                   r_lr_prev;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;

    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       r_left_hold;
    logic [c_cnt_w-1:0]     r_count;

    logic                   w_bclk_s;
    logic                   w_lr_s;
    logic                   w_dat_s;
    logic                   w_bclk_rise;
    logic                   w_slot_chg;
    logic [WIDTH-1:0]       w_bit_mask;
    logic                   w_capture;
    logic                   w_enter_left;
    logic                   w_left_done;
    logic                   w_pair_done;
    logic                   w_consume;

    // All three inputs share one chain depth so BCLK/LRCLK/data stay aligned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_dat_sync   <= '0;
            r_bclk_prev  <= 1'b0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bclk_in};
            r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], lrclk_in};
            r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], adcdat_in};
            r_bclk_prev  <= w_bclk_s;
        end
    end

    assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
    assign w_lr_s      = r_lrclk_sync[SYNC_STAGES-1];
    assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk_s & ~r_bclk_prev;
    assign w_slot_chg  = w_bclk_rise & (w_lr_s != r_lr_prev);
    assign w_bit_mask  = c_msb >> r_count;
    assign w_consume   = sample_valid & sample_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:      w_state_next = c_st_wait_left;
                c_st_wait_left: if (w_slot_chg && !w_lr_s) w_state_next = c_st_left;
                c_st_left:      if (w_slot_chg && w_lr_s)  w_state_next = c_st_right;
                c_st_right:     if (w_slot_chg && !w_lr_s) w_state_next = c_st_left;
                default:        w_state_next = c_st_idle;
            endcase
        end
    end

    always_comb begin
        locked       = 1'b0;
        w_capture    = 1'b0;
        w_enter_left = 1'b0;
        w_left_done  = 1'b0;
        w_pair_done  = 1'b0;
        case (r_state)
            c_st_wait_left: begin
                w_enter_left = enable & w_slot_chg & ~w_lr_s;
            end
            c_st_left: begin
                locked      = 1'b1;
                w_left_done = enable & w_slot_chg & w_lr_s;
                w_capture   = enable & w_bclk_rise & ~w_slot_chg & (r_count < c_full);
            end
            c_st_right: begin
                locked      = 1'b1;
                w_pair_done = enable & w_slot_chg & ~w_lr_s;
                w_capture   = enable & w_bclk_rise & ~w_slot_chg & (r_count < c_full);
            end
            default: ;
        endcase
    end

    // Slot-change edge carries the I2S delay bit, so it never captures.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lr_prev   <= 1'b0;
            r_shift     <= '0;
            r_count     <= '0;
            r_left_hold <= '0;
        end else begin
            if (w_bclk_rise) begin
                r_lr_prev <= w_lr_s;
            end
            if (r_state == c_st_idle || w_enter_left || w_left_done || w_pair_done) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_capture) begin
                r_shift <= r_shift | ({WIDTH{w_dat_s}} & w_bit_mask);
                r_count <= r_count + 1'b1;
            end
            if (w_left_done) begin
                r_left_hold <= r_shift;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (!enable) begin
                sample_valid <= 1'b0;
            end else if (w_pair_done && (!sample_valid || w_consume)) begin
                sample_l     <= r_left_hold;
                sample_r     <= r_shift;
                sample_valid <= 1'b1;
            end else if (w_consume) begin
                sample_valid <= 1'b0;
            end
            if (w_pair_done && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ssm2603_adc_receiver.sv
//------------------------------------------------------------------------------
// Module   : tb_ssm2603_adc_receiver
// Brief    : Directed I2S frames against a slot-level model of the receiver.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ssm2603_adc_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        bclk_in = 1'b0;
    logic        lrclk_in = 1'b0;
    logic        adcdat_in = 1'b0;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        overrun;
    logic        overrun_clear = 1'b0;
    logic        locked;

    ssm2603_adc_receiver #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .bclk_in      (bclk_in),
        .lrclk_in     (lrclk_in),
        .adcdat_in    (adcdat_in),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clear(overrun_clear),
        .locked       (locked)
    );

    always #5 clock = ~clock;

    int  errors = 0;
    int  checks = 0;
    time last_change = 0;

    // Slot-level model: 0 off, 1 hunting for a left slot, 2 in left, 3 in right.
    int          m_state = 0;
    logic        m_last_lr = 1'b0;
    logic [15:0] m_slot_word = 16'h0;
    logic [15:0] m_left = 16'h0;
    logic        m_consume_now = 1'b0;
    logic [15:0] exp_l = 16'h0;
    logic [15:0] exp_r = 16'h0;
    logic        exp_valid = 1'b0;
    logic        exp_overrun = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mark();
        last_change = $time;
    endtask

    task automatic model_pair(input logic [15:0] l, input logic [15:0] r);
        if (!exp_valid || m_consume_now) begin
            exp_l     = l;
            exp_r     = r;
            exp_valid = 1'b1;
        end else begin
            exp_overrun = 1'b1;
        end
    endtask

    task automatic model_slot_start(input logic lr);
        if (lr != m_last_lr) begin
            case (m_state)
                1: if (!lr) m_state = 2;
                2: if (lr) begin m_left = m_slot_word; m_state = 3; end
                3: if (!lr) begin model_pair(m_left, m_slot_word); m_state = 2; end
                default: ;
            endcase
        end
        m_last_lr = lr;
    endtask

    task automatic model_reset();
        m_state = 0; m_last_lr = 1'b0; m_slot_word = 16'h0; m_left = 16'h0;
        exp_l = 16'h0; exp_r = 16'h0; exp_valid = 1'b0; exp_overrun = 1'b0;
    endtask

    // Starts and ends on a clock negedge; 8 clocks low, 8 clocks high.
    task automatic send_bit(input logic lr, input logic d, input bit first,
                            input bit ready_edge, input logic [15:0] word);
        bclk_in = 1'b0; lrclk_in = lr; adcdat_in = d; mark();
        repeat (8) @(negedge clock);
        bclk_in = 1'b1; mark();
        if (first) begin
            m_consume_now = ready_edge;
            model_slot_start(lr);
            m_consume_now = 1'b0;
            m_slot_word = word;
        end
        if (ready_edge) begin
            repeat (2) @(negedge clock);
            chk("simul_pre_valid", 32'(sample_valid), 32'h1);
            chk("simul_pre_l", 32'(sample_l), 32'h1234);
            sample_ready = 1'b1; mark();
            @(negedge clock);
            sample_ready = 1'b0; mark();
            chk("simul_post_valid", 32'(sample_valid), 32'h1);
            chk("simul_post_l", 32'(sample_l), 32'h0123);
            chk("simul_post_r", 32'(sample_r), 32'h4567);
            chk("simul_post_ovr", 32'(overrun), 32'h0);
            repeat (5) @(negedge clock);
        end else begin
            repeat (8) @(negedge clock);
        end
    endtask

    // One delay bit followed by nbits payload bits taken MSB-first from v.
    task automatic send_slot(input logic lr, input logic [31:0] v, input int nbits,
                             input bit ready_edge);
        int          keep;
        logic [15:0] word;
        keep = (nbits < 16) ? nbits : 16;
        word = v[31:16] & ~(16'hFFFF >> keep);
        send_bit(lr, 1'b1, 1'b1, ready_edge, word);
        for (int i = 0; i < nbits; i++) begin
            send_bit(lr, v[31-i], 1'b0, 1'b0, word);
        end
    endtask

    task automatic consume();
        sample_ready = 1'b1; mark();
        @(negedge clock);
        sample_ready = 1'b0; exp_valid = 1'b0; mark();
        repeat (2) @(negedge clock);
    endtask

    task automatic check_pair(input string name, input logic [15:0] l, input logic [15:0] r);
        chk({name, "_valid"}, 32'(sample_valid), 32'h1);
        chk({name, "_l"}, 32'(sample_l), 32'(l));
        chk({name, "_r"}, 32'(sample_r), 32'(r));
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                if ($time - last_change >= 40) begin
                    checks++;
                    if ({sample_l, sample_r, sample_valid, overrun, locked} !==
                        {exp_l, exp_r, exp_valid, exp_overrun, (m_state >= 2)}) begin
                        errors++;
                        $display("FAIL model_cmp t=%0t: got l=%h r=%h v=%b ov=%b lk=%b expected l=%h r=%h v=%b ov=%b lk=%b",
                                 $time, sample_l, sample_r, sample_valid, overrun, locked,
                                 exp_l, exp_r, exp_valid, exp_overrun, (m_state >= 2));
                    end
                end
            end
        join_none

        @(negedge clock);
        chk("rst_l", 32'(sample_l), 32'h0);
        chk("rst_r", 32'(sample_r), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        reset = 1'b1; mark();
        repeat (3) @(negedge clock);
        enable = 1'b1; m_state = 1; mark();
        repeat (4) @(negedge clock);

        // Stream begins mid-right-slot: nothing until a left slot is seen.
        send_slot(1'b1, 32'hFFFF0000, 8, 1'b0);
        chk("prelock_locked", 32'(locked), 32'h0);
        chk("prelock_valid", 32'(sample_valid), 32'h0);
        send_slot(1'b0, 32'hA5C30000, 16, 1'b0);
        chk("lock_locked", 32'(locked), 32'h1);
        send_slot(1'b1, 32'h0F810000, 16, 1'b0);
        chk("no_pair_yet", 32'(sample_valid), 32'h0);

        send_slot(1'b0, 32'h8001FF00, 24, 1'b0);
        check_pair("first", 16'hA5C3, 16'h0F81);
        chk("model_pin_first", 32'(exp_l), 32'hA5C3);
        consume();
        chk("consumed_valid", 32'(sample_valid), 32'h0);

        send_slot(1'b1, 32'h7FFEFF00, 24, 1'b0);
        send_slot(1'b0, 32'hABC00000, 12, 1'b0);
        check_pair("long", 16'h8001, 16'h7FFE);
        consume();

        send_slot(1'b1, 32'hABC00000, 12, 1'b0);
        send_slot(1'b0, 32'h12340000, 16, 1'b0);
        check_pair("short", 16'hABC0, 16'hABC0);
        chk("model_pin_short", 32'(exp_r), 32'hABC0);
        consume();

        // Backpressure: 1234/5678 held, 9ABC/DEF0 dropped.
        send_slot(1'b1, 32'h56780000, 16, 1'b0);
        send_slot(1'b0, 32'h9ABC0000, 16, 1'b0);
        check_pair("bp_first", 16'h1234, 16'h5678);
        chk("bp_no_ovr", 32'(overrun), 32'h0);
        send_slot(1'b1, 32'hDEF00000, 16, 1'b0);
        send_slot(1'b0, 32'h01230000, 16, 1'b0);
        check_pair("bp_held", 16'h1234, 16'h5678);
        chk("bp_ovr_set", 32'(overrun), 32'h1);
        overrun_clear = 1'b1; mark();
        @(negedge clock);
        overrun_clear = 1'b0; exp_overrun = 1'b0; mark();
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // Ready lands exactly on the completion cycle of 0123/4567.
        send_slot(1'b1, 32'h45670000, 16, 1'b0);
        send_slot(1'b0, 32'h89AB0000, 16, 1'b1);
        consume();

        // Disable partway into a left slot.
        send_slot(1'b1, 32'hCDEF0000, 16, 1'b0);
        send_slot(1'b0, 32'h11110000, 5, 1'b0);
        check_pair("pre_dis", 16'h89AB, 16'hCDEF);
        enable = 1'b0; m_state = 0; exp_valid = 1'b0; mark();
        repeat (4) @(negedge clock);
        chk("dis_valid", 32'(sample_valid), 32'h0);
        chk("dis_locked", 32'(locked), 32'h0);
        chk("dis_l_kept", 32'(sample_l), 32'h89AB);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b0, 1'b0, m_slot_word);
        enable = 1'b1; m_state = 1; mark();
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, m_slot_word);
        send_slot(1'b1, 32'h22220000, 16, 1'b0);
        chk("reen_wait_locked", 32'(locked), 32'h0);
        chk("reen_wait_valid", 32'(sample_valid), 32'h0);
        send_slot(1'b0, 32'h33330000, 16, 1'b0);
        chk("reen_locked", 32'(locked), 32'h1);
        send_slot(1'b1, 32'h44440000, 16, 1'b0);
        send_slot(1'b0, 32'h55550000, 16, 1'b0);
        check_pair("reen_pair", 16'h3333, 16'h4444);

        // Asynchronous reset mid-slot.
        send_slot(1'b1, 32'h66660000, 8, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_l", 32'(sample_l), 32'h0);
        chk("arst_r", 32'(sample_r), 32'h0);
        chk("arst_valid", 32'(sample_valid), 32'h0);
        chk("arst_locked", 32'(locked), 32'h0);
        model_reset(); mark();
        repeat (8) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
